// File: rtl/i2c_slave_pkg.sv
// Shared definitions for the I2C slave byte controller.
//   state_t   : byte/ACK sequencer states
//   ADDR_W    : width of the 7-bit slave address
//   BYTE_W    : width of one transferred byte
//   ACK/NACK  : level driven (or left released) in an acknowledge slot
package i2c_slave_pkg;

  localparam int ADDR_W = 7;
  localparam int BYTE_W = 8;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    RX_DATA   = 3'd3,
    RX_ACK    = 3'd4,
    TX_DATA   = 3'd5,
    TX_ACK    = 3'd6,
    WAIT_STOP = 3'd7
  } state_t;

endpackage

// File: rtl/slave_bus_sync.sv
// Synchronizes raw SCL/SDA into the clk domain and turns their transitions
// into single-cycle event strobes.
// Ports:
//   clk, rst           : system clock, synchronous active-high reset
//   scl_in, sda_in     : raw pin levels
//   scl_rise, scl_fall : one-cycle strobes on synchronized SCL edges
//   start_det          : SDA fell while SCL was high
//   stop_det           : SDA rose while SCL was high
//   sda_level          : synchronized SDA, aligned with the strobes
// Every strobe is registered, so it appears SYNC_STAGES+1 clocks after the
// pin change.
module slave_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_level
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic scl_hist_q, scl_hist_d;
  logic sda_hist_q, sda_hist_d;
  logic scl_rise_q, scl_rise_d;
  logic scl_fall_q, scl_fall_d;
  logic start_q, start_d;
  logic stop_q, stop_d;
  logic sda_lvl_q, sda_lvl_d;
  logic scl_s, sda_s;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  // Synchronizer shift, history flops and event decode.
  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    scl_hist_d = scl_s;
    sda_hist_d = sda_s;
    scl_rise_d = scl_s & ~scl_hist_q;
    scl_fall_d = ~scl_s & scl_hist_q;
    // SCL must be high on both sides of the SDA edge to count as a condition
    start_d    = scl_s & scl_hist_q & ~sda_s & sda_hist_q;
    stop_d     = scl_s & scl_hist_q & sda_s & ~sda_hist_q;
    sda_lvl_d  = sda_s;
  end

  // Register stage; the idle bus is high so the chains reset high to avoid
  // a false edge right after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= {SYNC_STAGES{1'b1}};
      sda_sync_q <= {SYNC_STAGES{1'b1}};
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      sda_lvl_q  <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
      scl_rise_q <= scl_rise_d;
      scl_fall_q <= scl_fall_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      sda_lvl_q  <= sda_lvl_d;
    end
  end

  assign scl_rise  = scl_rise_q;
  assign scl_fall  = scl_fall_q;
  assign start_det = start_q;
  assign stop_det  = stop_q;
  assign sda_level = sda_lvl_q;

endmodule

// File: rtl/slave_byte_ctrl.sv
// Bit/byte level I2C slave controller driven by oversampled SCL/SDA.
// Ports:
//   clk, rst              : system clock (>= 8x SCL), sync active-high reset
//   scl_in, sda_in        : raw bus pin levels
//   slave_tx_data         : byte to send on a read, captured on slave_tx_load
//   slave_rx_full         : consumer full; received data byte gets NACKed
//   slave_mux_sel         : 1 = data bit drives SDA path, 0 = ack bit
//   slave_serial_out_data : current transmit bit, MSB first
//   slave_acknowledge     : 0 = ACK (pull low), 1 = NACK/released
//   slave_sda_oe          : 1 = slave may pull SDA low per mux output
//   slave_rx_data         : last received data byte
//   slave_rx_valid        : one-cycle pulse when slave_rx_data updates
//   slave_tx_load         : one-cycle pulse when slave_tx_data is captured
//   slave_busy            : controller not idle
module slave_byte_ctrl
  import i2c_slave_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SLAVE_ADDR  = 7'h50,
  parameter int                SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_in,
  input  logic              sda_in,
  input  logic [BYTE_W-1:0] slave_tx_data,
  input  logic              slave_rx_full,
  output logic              slave_mux_sel,
  output logic              slave_serial_out_data,
  output logic              slave_acknowledge,
  output logic              slave_sda_oe,
  output logic [BYTE_W-1:0] slave_rx_data,
  output logic              slave_rx_valid,
  output logic              slave_tx_load,
  output logic              slave_busy
);

  logic scl_rise_s, scl_fall_s, start_s, stop_s, sda_s;

  slave_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise_s),
    .scl_fall  (scl_fall_s),
    .start_det (start_s),
    .stop_det  (stop_s),
    .sda_level (sda_s)
  );

  state_t            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic [BYTE_W-2:0] tx_sr_q, tx_sr_d;      // bits still to send after ser_out
  logic              byte_done_q, byte_done_d; // 8th rise of the byte seen
  logic              rw_q, rw_d;
  logic              mack_q, mack_d;        // master's ack bit on a read
  logic              nack_q, nack_d;        // our verdict on the received byte
  logic              mux_sel_q, mux_sel_d;
  logic              ser_out_q, ser_out_d;
  logic              ack_q, ack_d;
  logic              sda_oe_q, sda_oe_d;
  logic [BYTE_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              tx_load_q, tx_load_d;
  logic              busy_q, busy_d;
  logic [BYTE_W-1:0] rx_byte_s;

  assign rx_byte_s = {shift_q[BYTE_W-2:0], sda_s};

  // Next-state and next-output logic of the byte/ACK sequencer.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_sr_d     = tx_sr_q;
    byte_done_d = byte_done_q;
    rw_d        = rw_q;
    mack_d      = mack_q;
    nack_d      = nack_q;
    mux_sel_d   = mux_sel_q;
    ser_out_d   = ser_out_q;
    ack_d       = ack_q;
    sda_oe_d    = sda_oe_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_load_d   = 1'b0;

    // Bus conditions win over any SCL edge decoded in the same cycle.
    if (start_s || stop_s) begin
      state_d     = start_s ? ADDR : IDLE;
      bit_cnt_d   = 3'd0;
      byte_done_d = 1'b0;
      sda_oe_d    = 1'b0;
      mux_sel_d   = 1'b0;
      ack_d       = NACK;
      ser_out_d   = 1'b1;
    end else begin
      case (state_q)
        ADDR, RX_DATA: begin
          if (scl_rise_s) begin
            shift_d     = rx_byte_s;
            bit_cnt_d   = bit_cnt_q + 3'd1;
            byte_done_d = (bit_cnt_q == 3'd7);
            // The rx_full level seen at the 8th rise decides both the
            // update and the ack, so the two always agree.
            if ((state_q == RX_DATA) && (bit_cnt_q == 3'd7)) begin
              nack_d = slave_rx_full;
              if (!slave_rx_full) begin
                rx_data_d  = rx_byte_s;
                rx_valid_d = 1'b1;
              end else begin
                rx_data_d = rx_data_q;
              end
            end else begin
              nack_d = nack_q;
            end
          end else if (scl_fall_s && byte_done_q) begin
            byte_done_d = 1'b0;
            mux_sel_d   = 1'b0;
            if (state_q == RX_DATA) begin
              state_d  = RX_ACK;
              sda_oe_d = 1'b1;
              ack_d    = nack_q;
            end else if (shift_q[BYTE_W-1:1] == SLAVE_ADDR) begin
              state_d  = ADDR_ACK;
              rw_d     = shift_q[0];
              sda_oe_d = 1'b1;
              ack_d    = ACK;
            end else begin
              state_d = WAIT_STOP;
            end
          end else begin
            state_d = state_q;
          end
        end
        ADDR_ACK, TX_ACK: begin
          if (scl_rise_s) begin
            mack_d = sda_s;
          end else if (scl_fall_s) begin
            bit_cnt_d   = 3'd0;
            byte_done_d = 1'b0;
            ack_d       = NACK;
            if ((state_q == ADDR_ACK) ? rw_q : (mack_q == ACK)) begin
              state_d   = TX_DATA;
              tx_sr_d   = slave_tx_data[BYTE_W-2:0];
              ser_out_d = slave_tx_data[BYTE_W-1];
              tx_load_d = 1'b1;
              mux_sel_d = 1'b1;
              sda_oe_d  = 1'b1;
            end else begin
              state_d   = (state_q == ADDR_ACK) ? RX_DATA : WAIT_STOP;
              mux_sel_d = 1'b0;
              sda_oe_d  = 1'b0;
            end
          end else begin
            state_d = state_q;
          end
        end
        RX_ACK: begin
          if (scl_fall_s) begin
            state_d   = (ack_q == ACK) ? RX_DATA : WAIT_STOP;
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
            mux_sel_d = 1'b0;
            ack_d     = NACK;
          end else begin
            state_d = RX_ACK;
          end
        end
        TX_DATA: begin
          if (scl_rise_s) begin
            bit_cnt_d   = bit_cnt_q + 3'd1;
            byte_done_d = (bit_cnt_q == 3'd7);
          end else if (scl_fall_s && byte_done_q) begin
            state_d     = TX_ACK;
            byte_done_d = 1'b0;
            sda_oe_d    = 1'b0;
            mux_sel_d   = 1'b0;
            ack_d       = NACK;
            ser_out_d   = 1'b1;
          end else if (scl_fall_s) begin
            ser_out_d = tx_sr_q[BYTE_W-2];
            tx_sr_d   = {tx_sr_q[BYTE_W-3:0], 1'b0};
          end else begin
            state_d = TX_DATA;
          end
        end
        IDLE, WAIT_STOP: begin
          state_d = state_q;
        end
        default: begin
          state_d   = IDLE;
          sda_oe_d  = 1'b0;
          mux_sel_d = 1'b0;
          ack_d     = NACK;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      tx_sr_q     <= 7'h00;
      byte_done_q <= 1'b0;
      rw_q        <= 1'b0;
      mack_q      <= 1'b1;
      nack_q      <= 1'b0;
      mux_sel_q   <= 1'b0;
      ser_out_q   <= 1'b1;
      ack_q       <= NACK;
      sda_oe_q    <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      tx_load_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_sr_q     <= tx_sr_d;
      byte_done_q <= byte_done_d;
      rw_q        <= rw_d;
      mack_q      <= mack_d;
      nack_q      <= nack_d;
      mux_sel_q   <= mux_sel_d;
      ser_out_q   <= ser_out_d;
      ack_q       <= ack_d;
      sda_oe_q    <= sda_oe_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_load_q   <= tx_load_d;
      busy_q      <= busy_d;
    end
  end

  assign slave_mux_sel         = mux_sel_q;
  assign slave_serial_out_data = ser_out_q;
  assign slave_acknowledge     = ack_q;
  assign slave_sda_oe          = sda_oe_q;
  assign slave_rx_data         = rx_data_q;
  assign slave_rx_valid        = rx_valid_q;
  assign slave_tx_load         = tx_load_q;
  assign slave_busy            = busy_q;

endmodule

// File: tb/tb_slave_byte_ctrl.sv
// Self-checking bench for slave_byte_ctrl: a bit-banged I2C master with a
// wired-AND SDA, a table of write transactions, and hand-written read,
// repeated-start, STOP-abort and reset sequences. Received and transmitted
// bytes are checked through scoreboard queues.
module tb_slave_byte_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m, sda_m;
  logic [7:0] tx_data;
  logic       rx_full;
  logic       sel, sout, ack, oe;
  logic [7:0] rx_data;
  logic       rx_valid, tx_load, busy;
  logic       sda_bus;

  always #5 clk = ~clk;

  // Open-drain bus: the slave pulls low when enabled and its muxed bit is 0.
  assign sda_bus = sda_m & ~(oe & ~(sel ? sout : ack));

  slave_byte_ctrl #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .scl_in                (scl_m),
    .sda_in                (sda_bus),
    .slave_tx_data         (tx_data),
    .slave_rx_full         (rx_full),
    .slave_mux_sel         (sel),
    .slave_serial_out_data (sout),
    .slave_acknowledge     (ack),
    .slave_sda_oe          (oe),
    .slave_rx_data         (rx_data),
    .slave_rx_valid        (rx_valid),
    .slave_tx_load         (tx_load),
    .slave_busy            (busy)
  );

  int total = 0;
  int bad   = 0;
  int rx_cnt = 0;
  int load_cnt = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       full;
    logic       exp_addr_bus;  // SDA seen in address ack slot
    logic       exp_addr_oe;
    logic       exp_data_ack;  // slave_acknowledge in data ack slot
    logic       exp_data_oe;
    int         exp_rx;        // rx_valid pulses expected
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock; also scoreboards rx_valid and counts tx_load pulses.
  task automatic tick();
    @(negedge clk);
    if (tx_load === 1'b1) load_cnt++;
    if (rx_valid === 1'b1) begin
      rx_cnt++;
      if (rx_q.size() > 0) check("rx_data", {24'h0, rx_data}, {24'h0, rx_q.pop_front()});
      else check("rx_valid_unexpected", {31'h0, rx_valid}, 32'h0);
    end
  endtask

  task automatic wait_clk(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // One SCL period with the master driving b; samples bus and slave
  // outputs in the middle of the high phase.
  task automatic clk_bit(input logic b, output logic bus_v, output logic oe_v,
                         output logic ack_v, output logic sel_v);
    scl_m = 1'b0; wait_clk(4);
    sda_m = b;    wait_clk(4);
    scl_m = 1'b1; wait_clk(6);
    bus_v = sda_bus; oe_v = oe; ack_v = ack; sel_v = sel;
    wait_clk(2);
  endtask

  task automatic i2c_start();
    scl_m = 1'b0; wait_clk(4);
    sda_m = 1'b1; wait_clk(4);
    scl_m = 1'b1; wait_clk(8);
    sda_m = 1'b0; wait_clk(8);
  endtask

  task automatic i2c_stop();
    scl_m = 1'b0; wait_clk(4);
    sda_m = 1'b0; wait_clk(4);
    scl_m = 1'b1; wait_clk(8);
    sda_m = 1'b1; wait_clk(8);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack_bus,
                           output logic ack_oe, output logic ack_out);
    logic bv, ov, av, sv;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], bv, ov, av, sv);
    clk_bit(1'b1, ack_bus, ack_oe, ack_out, sv);
  endtask

  task automatic read_byte(input logic m_ack, output logic [7:0] val, output logic drv_all);
    logic bv, ov, av, sv;
    drv_all = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, bv, ov, av, sv);
      val[i] = bv;
      drv_all = drv_all & ov & sv;
    end
    clk_bit(m_ack, bv, ov, av, sv);
  endtask

  task automatic send_bits4(input logic [3:0] b);
    logic bv, ov, av, sv;
    for (int i = 3; i >= 0; i--) clk_bit(b[i], bv, ov, av, sv);
  endtask

  initial begin
    logic       abus, aoe, aack, dbus, doe, dack, drv;
    logic [7:0] val;
    int         rx0, ld0;

    vecs[0] = '{8'hA0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1};
    vecs[1] = '{8'h42, 8'h55, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0};
    vecs[2] = '{8'hA0, 8'h11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 0};
    vecs[3] = '{8'hA0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1};
    vecs[4] = '{8'hA2, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0};
    vecs[5] = '{8'hA0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1};
    vecs[6] = '{8'h20, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0};

    // Reset values
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; tx_data = 8'h00; rx_full = 1'b0;
    wait_clk(3);
    check("rst_sel",  {31'h0, sel},  32'h0);
    check("rst_ack",  {31'h0, ack},  32'h1);
    check("rst_sout", {31'h0, sout}, 32'h1);
    check("rst_oe",   {31'h0, oe},   32'h0);
    check("rst_rxd",  {24'h0, rx_data}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;
    wait_clk(4);

    // Table of write transactions
    for (int r = 0; r < 7; r++) begin
      rx0 = rx_cnt;
      rx_full = vecs[r].full;
      i2c_start();
      check("start_busy", {31'h0, busy}, 32'h1);
      send_byte(vecs[r].addr, abus, aoe, aack);
      check("addr_ack_bus", {31'h0, abus}, {31'h0, vecs[r].exp_addr_bus});
      check("addr_ack_oe",  {31'h0, aoe},  {31'h0, vecs[r].exp_addr_oe});
      if (vecs[r].exp_rx != 0) rx_q.push_back(vecs[r].data);
      send_byte(vecs[r].data, dbus, doe, dack);
      check("data_ack_out", {31'h0, dack}, {31'h0, vecs[r].exp_data_ack});
      check("data_ack_oe",  {31'h0, doe},  {31'h0, vecs[r].exp_data_oe});
      rx_full = 1'b0;
      i2c_stop();
      check("rx_valid_count", rx_cnt - rx0, vecs[r].exp_rx);
      check("stop_busy", {31'h0, busy}, 32'h0);
    end

    // Read two bytes: 0x3C with master ACK, 0xC3 with master NACK
    ld0 = load_cnt;
    tx_data = 8'h3C; tx_q.push_back(8'h3C);
    i2c_start();
    send_byte(8'hA1, abus, aoe, aack);
    check("rd_addr_ack", {31'h0, abus}, 32'h0);
    read_byte(1'b0, val, drv);
    check("rd_byte0", {24'h0, val}, {24'h0, tx_q.pop_front()});
    check("rd_drive0", {31'h0, drv}, 32'h1);
    tx_data = 8'hC3; tx_q.push_back(8'hC3);
    read_byte(1'b1, val, drv);
    check("rd_byte1", {24'h0, val}, {24'h0, tx_q.pop_front()});
    i2c_stop();
    check("rd_loads", load_cnt - ld0, 2);
    check("rd_busy", {31'h0, busy}, 32'h0);

    // Repeated START in the middle of a write data byte
    ld0 = load_cnt;
    i2c_start();
    send_byte(8'hA0, abus, aoe, aack);
    check("rs_w_ack", {31'h0, abus}, 32'h0);
    send_bits4(4'b1010);
    tx_data = 8'h96; tx_q.push_back(8'h96);
    i2c_start();
    send_byte(8'hA1, abus, aoe, aack);
    check("rs_r_ack", {31'h0, abus}, 32'h0);
    check("rs_r_oe",  {31'h0, aoe},  32'h1);
    read_byte(1'b1, val, drv);
    check("rs_byte", {24'h0, val}, {24'h0, tx_q.pop_front()});
    check("rs_drive", {31'h0, drv}, 32'h1);
    i2c_stop();
    check("rs_loads", load_cnt - ld0, 1);

    // STOP at bit 4 of a data byte aborts without rx_valid
    rx0 = rx_cnt;
    i2c_start();
    send_byte(8'hA0, abus, aoe, aack);
    send_bits4(4'b1111);
    i2c_stop();
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_oe",   {31'h0, oe},   32'h0);
    check("abort_rx",   rx_cnt - rx0, 0);

    // A clean write after the abort starts its bit count from zero
    rx0 = rx_cnt;
    rx_q.push_back(8'h5A);
    i2c_start();
    send_byte(8'hA0, abus, aoe, aack);
    send_byte(8'h5A, dbus, doe, dack);
    check("post_abort_ack", {31'h0, dbus}, 32'h0);
    i2c_stop();
    check("post_abort_rx", rx_cnt - rx0, 1);

    // Reset at bit 4 of a data byte
    i2c_start();
    send_byte(8'hA0, abus, aoe, aack);
    send_bits4(4'b1111);
    check("pre_rst_busy", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    tick();
    check("mid_rst_sel",  {31'h0, sel},  32'h0);
    check("mid_rst_ack",  {31'h0, ack},  32'h1);
    check("mid_rst_sout", {31'h0, sout}, 32'h1);
    check("mid_rst_oe",   {31'h0, oe},   32'h0);
    check("mid_rst_rxd",  {24'h0, rx_data}, 32'h0);
    check("mid_rst_rxv",  {31'h0, rx_valid}, 32'h0);
    check("mid_rst_load", {31'h0, tx_load}, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;
    wait_clk(10);
    check("final_busy", {31'h0, busy}, 32'h0);
    check("rx_q_drained", rx_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
